// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   - FSM state encoding (IDLE=0 .. WAIT_HIGH=4), kept as plain logic
//     constants so older blocks that compare raw state values still line up.
//   - Helpers that derive clocks-per-bit and half-bit counts from the
//     clock frequency and bit rate.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int calc_cpb(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Cycles from the detected start edge to the middle of the start bit.
    function automatic int calc_half(input int cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk       - destination clock
//   rst       - synchronous, active-high reset; both flops load RESET_VAL
//   d         - asynchronous input
//   q         - synchronized output, two clk cycles behind d
// Also used for push-button inputs, hence the parameterised reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops are written with non-blocking assignments so that q picks up
    // the old value of meta, giving a true two-stage pipeline rather than a wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 (LSB-first) UART receiver.
//   clk               - system clock (single domain)
//   rst               - synchronous, active-high reset
//   uart_rxd          - asynchronous serial input, idles high
//   uart_rx_data      - last correctly framed byte, held until the next one
//   uart_rx_valid     - one-cycle strobe: uart_rx_data is new this cycle
//   uart_rx_frame_err - one-cycle strobe: stop bit was sampled low
// Each bit is sampled once at its centre, timed from the detected start edge.
// After a bad stop bit the receiver waits for the line to return high so a
// held-low (break) line is not decoded as a stream of start bits.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rxd,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err
);

    localparam int CPB   = calc_cpb(CLK_HZ, BIT_RATE);
    localparam int HALF  = calc_half(CPB);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int IDX_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

    // Below 4 clocks per bit there is no usable bit centre to sample at.
    generate
        if (CPB < 4) begin : g_cpb_too_small
            $error("uart_byte_rx: CLK_HZ/BIT_RATE must be at least 4");
        end
    endgenerate

    logic                    rxd_s;
    logic [2:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [PAYLOAD_BITS:0]   shift_ext;
    logic                    cnt_zero;
    logic                    data_sample;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rxd),
        .q   (rxd_s)
    );

    assign cnt_zero    = (cnt == '0);
    assign data_sample = (state == ST_DATA) && cnt_zero;

    // New bit enters at the MSB; after PAYLOAD_BITS shifts the first bit
    // received sits at bit 0. Written this way to stay legal for 1-bit payloads.
    assign shift_ext = {rxd_s, shift_reg};

    // NOTE: the shift register is deliberately not reset: it is fully
    // overwritten by every frame before it can reach uart_rx_data.
    always_ff @(posedge clk) begin
        if (data_sample) begin
            shift_reg <= shift_ext[PAYLOAD_BITS:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below raises them.
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        cnt   <= CNT_HALF;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt_zero) begin
                        if (!rxd_s) begin
                            cnt     <= CNT_FULL;
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            // Line already back high at mid-start: a glitch.
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt_zero) begin
                        cnt     <= CNT_FULL;
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (cnt_zero) begin
                        // Leaving at mid-stop-bit lets an immediately
                        // following start edge be caught in IDLE.
                        if (rxd_s) begin
                            uart_rx_data  <= shift_reg;
                            uart_rx_valid <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            uart_rx_frame_err <= 1'b1;
                            state             <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_WAIT_HIGH: begin
                    if (rxd_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
